// File: rtl/seq_handshake_monitor_pkg.sv
// Shared types and helpers for the multi-channel handshake sequence monitor.
// Optional sticky/first-fail capture is enabled by defining SEQ_MON_STICKY_EN.
package seq_mon_pkg;

  typedef enum logic [2:0] {
    NONE       = 3'd0,
    EARLY_ACK  = 3'd1,
    TIMEOUT    = 3'd2,
    NO_DONE    = 3'd3,
    VALID_DROP = 3'd4
  } fail_code_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_DONE
  } chan_state_t;

  // Saturating increment on a w-bit value carried in 32 bits (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/seq_handshake_monitor_if.sv
// Handshake/status bundle between the monitored bus and seq_handshake_monitor.
interface seq_handshake_monitor_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
);
  logic [NUM_CH-1:0]       req;
  logic [NUM_CH-1:0]       ack;
  logic [NUM_CH-1:0]       done;
  logic [NUM_CH-1:0]       valid;
  logic [NUM_CH-1:0]       busy;
  logic [NUM_CH-1:0]       match;
  logic [NUM_CH-1:0]       fail;
  logic [3*NUM_CH-1:0]     fail_code;
  logic [CNT_W*NUM_CH-1:0] pass_cnt;
  logic [CNT_W*NUM_CH-1:0] fail_cnt;

  modport master (
    output req, ack, done, valid,
    input  busy, match, fail, fail_code, pass_cnt, fail_cnt
  );

  modport slave (
    input  req, ack, done, valid,
    output busy, match, fail, fail_code, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/seq_handshake_monitor_chan.sv
// One monitored channel: rise detect, req->ack delay window, done check,
// registered pass/fail pulses and saturating event counters.
module seq_mon_chan
  import seq_mon_pkg::*;
#(
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             req_i,
  input  logic             ack_i,
  input  logic             done_i,
  input  logic             valid_i,
  output logic             busy_o,
  output logic             match_o,
  output logic             fail_o,
  output fail_code_t       fail_code_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] fail_cnt_o
);
  localparam int unsigned KW = $clog2(MAX_DLY + 1);
  localparam logic [KW-1:0] MIN_K = KW'(MIN_DLY);
  localparam logic [KW-1:0] MAX_K = KW'(MAX_DLY);

  chan_state_t      state_q;
  logic [KW-1:0]    k_q;
  logic             req_q;
  logic             match_q;
  logic             fail_q;
  fail_code_t       code_q;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
      req_q   <= 1'b0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= NONE;
    end else begin
      req_q   <= req_i;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= NONE;
      unique case (state_q)
        IDLE: begin
          // valid is already qualified in the rise cycle itself
          if (req_i && !req_q) begin
            if (!valid_i) begin
              fail_q <= 1'b1;
              code_q <= VALID_DROP;
            end else begin
              state_q <= WAIT_ACK;
              k_q     <= KW'(1);
            end
          end
        end
        WAIT_ACK: begin
          if (!valid_i) begin
            state_q <= IDLE;
            fail_q  <= 1'b1;
            code_q  <= VALID_DROP;
          end else if (ack_i && (k_q < MIN_K)) begin
            state_q <= IDLE;
            fail_q  <= 1'b1;
            code_q  <= EARLY_ACK;
          end else if (ack_i) begin
            state_q <= WAIT_DONE;
          end else if (k_q == MAX_K) begin
            state_q <= IDLE;
            fail_q  <= 1'b1;
            code_q  <= TIMEOUT;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          state_q <= IDLE;
          if (done_i) begin
            match_q <= 1'b1;
          end else begin
            fail_q <= 1'b1;
            code_q <= NO_DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Counters follow the registered pulses, so clear in the pulse cycle drops that event.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clear_i) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (match_q) pass_cnt_d = CNT_W'(sat_inc(32'(pass_cnt_q), CNT_W));
      if (fail_q)  fail_cnt_d = CNT_W'(sat_inc(32'(fail_cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign match_o     = match_q;
  assign fail_o      = fail_q;
  assign fail_code_o = code_q;
  assign pass_cnt_o  = pass_cnt_q;
  assign fail_cnt_o  = fail_cnt_q;

endmodule

// File: rtl/seq_handshake_monitor.sv
// Multi-channel "$rose(req) ##[MIN:MAX] ack ##1 done" checker.
// Define SEQ_MON_STICKY_EN to add sticky fail flags and first-fail capture.
module seq_handshake_monitor
  import seq_mon_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned MIN_DLY = 1,
  parameter int unsigned MAX_DLY = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  seq_handshake_monitor_if.slave      bus
`ifdef SEQ_MON_STICKY_EN
  ,
  output logic [NUM_CH-1:0]           sticky_fail,
  output logic                        first_fail_vld,
  output logic [$clog2(NUM_CH)-1:0]   first_fail_ch,
  output logic [2:0]                  first_fail_code
`endif
);
  if (MIN_DLY < 1) begin : g_chk_min
    $error("seq_handshake_monitor: MIN_DLY must be >= 1");
  end
  if (MAX_DLY < MIN_DLY) begin : g_chk_max
    $error("seq_handshake_monitor: MAX_DLY must be >= MIN_DLY");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_chk_cnt
    $error("seq_handshake_monitor: CNT_W must be in 1..32");
  end

  logic [NUM_CH-1:0] fail_w;
  fail_code_t        code_w [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    seq_mon_chan #(
      .MIN_DLY(MIN_DLY),
      .MAX_DLY(MAX_DLY),
      .CNT_W  (CNT_W)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (reset),
      .clear_i    (clear),
      .req_i      (bus.req[g]),
      .ack_i      (bus.ack[g]),
      .done_i     (bus.done[g]),
      .valid_i    (bus.valid[g]),
      .busy_o     (bus.busy[g]),
      .match_o    (bus.match[g]),
      .fail_o     (fail_w[g]),
      .fail_code_o(code_w[g]),
      .pass_cnt_o (bus.pass_cnt[g*CNT_W +: CNT_W]),
      .fail_cnt_o (bus.fail_cnt[g*CNT_W +: CNT_W])
    );
    assign bus.fail_code[3*g +: 3] = code_w[g];
  end

  assign bus.fail = fail_w;

`ifdef SEQ_MON_STICKY_EN
  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] sticky_q;
  logic              ff_vld_q;
  logic [CH_W-1:0]   ff_ch_q, low_ch;
  fail_code_t        ff_code_q, low_code;

  // Descending scan so the lowest failing index is the one left standing.
  always_comb begin
    low_ch   = '0;
    low_code = NONE;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if (fail_w[i-1]) begin
        low_ch   = CH_W'(i - 1);
        low_code = code_w[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sticky_q  <= '0;
      ff_vld_q  <= 1'b0;
      ff_ch_q   <= '0;
      ff_code_q <= NONE;
    end else begin
      sticky_q <= sticky_q | fail_w;
      if (!ff_vld_q && (|fail_w)) begin
        ff_vld_q  <= 1'b1;
        ff_ch_q   <= low_ch;
        ff_code_q <= low_code;
      end
    end
  end

  assign sticky_fail     = sticky_q;
  assign first_fail_vld  = ff_vld_q;
  assign first_fail_ch   = ff_ch_q;
  assign first_fail_code = ff_code_q;
`endif

endmodule

// File: tb/tb_seq_handshake_monitor.sv
// Directed self-checking bench: default instance plus a MIN_DLY=2/CNT_W=2 instance.
module tb_seq_handshake_monitor;
  logic clk = 1'b0;
  logic reset;
  logic clear_a;
  logic clear_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_handshake_monitor_if #(.NUM_CH(4), .CNT_W(16)) ifa ();
  seq_handshake_monitor_if #(.NUM_CH(4), .CNT_W(2))  ifb ();

`ifdef SEQ_MON_STICKY_EN
  logic [3:0] sticky_a, sticky_b;
  logic       ffv_a, ffv_b;
  logic [1:0] ffch_a, ffch_b;
  logic [2:0] ffcode_a, ffcode_b;
`endif

  seq_handshake_monitor #(
    .NUM_CH(4), .MIN_DLY(1), .MAX_DLY(3), .CNT_W(16)
  ) dut_a (
    .clk  (clk),
    .reset(reset),
    .clear(clear_a),
    .bus  (ifa)
`ifdef SEQ_MON_STICKY_EN
    ,
    .sticky_fail    (sticky_a),
    .first_fail_vld (ffv_a),
    .first_fail_ch  (ffch_a),
    .first_fail_code(ffcode_a)
`endif
  );

  seq_handshake_monitor #(
    .NUM_CH(4), .MIN_DLY(2), .MAX_DLY(3), .CNT_W(2)
  ) dut_b (
    .clk  (clk),
    .reset(reset),
    .clear(clear_b),
    .bus  (ifb)
`ifdef SEQ_MON_STICKY_EN
    ,
    .sticky_fail    (sticky_b),
    .first_fail_vld (ffv_b),
    .first_fail_ch  (ffch_b),
    .first_fail_code(ffcode_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    clear_a = 1'b0;
    clear_b = 1'b0;
    ifa.req = '0; ifa.ack = '0; ifa.done = '0; ifa.valid = '0;
    ifb.req = '0; ifb.ack = '0; ifb.done = '0; ifb.valid = '0;
    // req held high through reset on dut_b ch3
    ifb.req[3]   = 1'b1;
    ifb.valid[3] = 1'b1;
    step(); step();

    chk("rst_busy_a",  ifa.busy, 0);
    chk("rst_match_a", ifa.match, 0);
    chk("rst_fail_a",  ifa.fail, 0);
    chk("rst_code_a",  ifa.fail_code, 0);
    chk("rst_pass_a",  ifa.pass_cnt[31:0], 0);
    chk("rst_failc_a", ifa.fail_cnt[31:0], 0);
    chk("rst_busy_b",  ifb.busy, 0);

    // req high right out of reset triggers
    reset = 1'b0;
    step();
    chk("rst_rise_busy_b3", ifb.busy[3], 1);
    ifb.req[3]   = 1'b0;
    ifb.valid[3] = 1'b0;
    step();
    chk("rst_rise_drop_fail", ifb.fail, 4'b1000);
    chk("rst_rise_drop_code", ifb.fail_code[11:9], 3'd4);
    step();

    // Test 1: ch0 ack at T+2, done at T+3; ack at T is ignored
    ifa.req[0] = 1'b1; ifa.valid[0] = 1'b1; ifa.ack[0] = 1'b1;
    step();                                       // T+1
    chk("t1_busy", ifa.busy[0], 1);
    ifa.ack[0] = 1'b0;
    step();                                       // T+2
    ifa.ack[0] = 1'b1;
    step();                                       // T+3
    ifa.ack[0] = 1'b0; ifa.done[0] = 1'b1;
    chk("t1_no_early_match", ifa.match, 0);
    step();                                       // T+4
    chk("t1_match", ifa.match, 4'b0001);
    chk("t1_fail", ifa.fail, 0);
    chk("t1_busy_end", ifa.busy[0], 0);
    ifa.done[0] = 1'b0; ifa.req[0] = 1'b0; ifa.valid[0] = 1'b0;
    step();                                       // T+5
    chk("t1_match_1cyc", ifa.match, 0);
    chk("t1_pass_cnt0", ifa.pass_cnt[15:0], 1);

    // Test 2: ch1 timeout; ch2 ack exactly at k=MAX then done
    ifa.req[1] = 1'b1; ifa.valid[1] = 1'b1;
    ifa.req[2] = 1'b1; ifa.valid[2] = 1'b1;
    step(); step();                               // T+2
    step();                                       // T+3
    ifa.ack[2] = 1'b1;
    step();                                       // T+4
    ifa.ack[2] = 1'b0; ifa.done[2] = 1'b1;
    chk("t2_timeout_fail", ifa.fail, 4'b0010);
    chk("t2_timeout_code", ifa.fail_code[5:3], 3'd2);
    chk("t2_busy1", ifa.busy[1], 0);
    chk("t2_busy2", ifa.busy[2], 1);
    step();                                       // T+5
    ifa.done[2] = 1'b0;
    ifa.req = '0; ifa.valid = '0;
    chk("t2_max_match", ifa.match, 4'b0100);
    chk("t2_fail_clr", ifa.fail, 0);
    chk("t2_code_none", ifa.fail_code, 0);
    step();
    chk("t2_fail_cnt1", ifa.fail_cnt[31:16], 1);
    chk("t2_pass_cnt2", ifa.pass_cnt[47:32], 1);

    // Test 4a: valid drops at T+1 together with ack
    ifa.req[3] = 1'b1; ifa.valid[3] = 1'b1;
    step();
    ifa.valid[3] = 1'b0; ifa.ack[3] = 1'b1;
    step();
    chk("t4_vdrop_fail", ifa.fail, 4'b1000);
    chk("t4_vdrop_code", ifa.fail_code[11:9], 3'd4);
    chk("t4_vdrop_nomatch", ifa.match, 0);
    ifa.req[3] = 1'b0; ifa.ack[3] = 1'b0;
    step();

    // valid low in the rise cycle itself
    ifa.req[0] = 1'b1;
    step();
    chk("t4_vlow_rise_fail", ifa.fail, 4'b0001);
    chk("t4_vlow_rise_code", ifa.fail_code[2:0], 3'd4);
    chk("t4_vlow_rise_busy", ifa.busy[0], 0);
    ifa.req[0] = 1'b0;
    step();
    chk("t4_fail_cnt0", ifa.fail_cnt[15:0], 1);

    // Test 4b: reset at T+1 aborts without a pulse and zeroes counters
    ifa.req[1] = 1'b1; ifa.valid[1] = 1'b1;
    step();
    chk("t4_rst_busy_pre", ifa.busy[1], 1);
    reset = 1'b1;
    ifa.req[1] = 1'b0; ifa.valid[1] = 1'b0;
    step();
    reset = 1'b0;
    chk("t4_rst_busy", ifa.busy, 0);
    chk("t4_rst_fail", ifa.fail, 0);
    chk("t4_rst_pass0", ifa.pass_cnt[15:0], 0);
    chk("t4_rst_fail1", ifa.fail_cnt[31:16], 0);
    step();
    chk("t4_rst_nopulse", {ifa.match, ifa.fail}, 0);

    // Test 3 (MIN_DLY=2): ch0 early ack; ch1 ack at T+2 without done
    ifb.req[0] = 1'b1; ifb.valid[0] = 1'b1;
    ifb.req[1] = 1'b1; ifb.valid[1] = 1'b1;
    step();                                       // T+1
    ifb.ack[0] = 1'b1;
    step();                                       // T+2
    ifb.ack[0] = 1'b0; ifb.ack[1] = 1'b1;
    chk("t3_early_fail", ifb.fail, 4'b0001);
    chk("t3_early_code", ifb.fail_code[2:0], 3'd1);
    chk("t3_early_busy", ifb.busy[0], 0);
    step();                                       // T+3
    ifb.ack[1] = 1'b0;
    chk("t3_quiet", ifb.fail, 0);
    step();                                       // T+4
    chk("t3_nodone_fail", ifb.fail, 4'b0010);
    chk("t3_nodone_code", ifb.fail_code[5:3], 3'd3);
    chk("t3_nodone_nomatch", ifb.match, 0);
    ifb.req = '0; ifb.valid = '0;
    step();

    // Test 5 (CNT_W=2): five matches on ch2 saturate at 3
    for (int i = 0; i < 5; i++) begin
      ifb.req[2] = 1'b1; ifb.valid[2] = 1'b1;
      step(); step();
      ifb.ack[2] = 1'b1;
      step();
      ifb.ack[2] = 1'b0; ifb.done[2] = 1'b1;
      step();
      chk("t5_loop_match", ifb.match, 4'b0100);
      ifb.done[2] = 1'b0; ifb.req[2] = 1'b0; ifb.valid[2] = 1'b0;
      step();
    end
    chk("t5_pass_sat", ifb.pass_cnt[5:4], 2'd3);

    // clear in the match pulse cycle: pulse survives, event not counted
    ifb.req[2] = 1'b1; ifb.valid[2] = 1'b1;
    step(); step();
    ifb.ack[2] = 1'b1;
    step();
    ifb.ack[2] = 1'b0; ifb.done[2] = 1'b1;
    step();
    chk("t5_clr_match_pulse", ifb.match, 4'b0100);
    clear_b = 1'b1;
    ifb.done[2] = 1'b0; ifb.req[2] = 1'b0; ifb.valid[2] = 1'b0;
    step();
    clear_b = 1'b0;
    chk("t5_clr_wins", ifb.pass_cnt[5:4], 2'd0);

`ifdef SEQ_MON_STICKY_EN
    // Test 6: ch2/ch3 fail together, later ch0 fail, then clear
    ifa.req[2] = 1'b1; ifa.req[3] = 1'b1;
    step();
    chk("t6_dual_fail", ifa.fail, 4'b1100);
    ifa.req[2] = 1'b0; ifa.req[3] = 1'b0;
    step();
    chk("t6_ff_vld", ffv_a, 1);
    chk("t6_ff_ch", ffch_a, 2);
    chk("t6_ff_code", ffcode_a, 3'd4);
    chk("t6_sticky", sticky_a, 4'b1100);
    ifa.req[0] = 1'b1;
    step();
    ifa.req[0] = 1'b0;
    step();
    chk("t6_ff_hold", ffch_a, 2);
    chk("t6_sticky2", sticky_a, 4'b1101);
    clear_a = 1'b1;
    step();
    clear_a = 1'b0;
    chk("t6_clr_vld", ffv_a, 0);
    chk("t6_clr_sticky", sticky_a, 0);
    chk("t6_clr_ch", ffch_a, 0);
    chk("t6_clr_code", ffcode_a, 0);
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
